// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD-to-binary converter and its digit MAC.
package bcd_to_bin_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  // Largest legal BCD nibble value
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Width of the packed BCD input word for a given number of decades
  function automatic int unsigned bcd_in_width(input int unsigned decades);
    return 4 * decades;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One BCD fold step: acc*10 + digit with saturation at 2^OUT_BITS-1.
module bcd_digit_mac
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned OUT_BITS = 14
) (
  input  logic [OUT_BITS-1:0] acc,
  input  logic [3:0]          digit,
  output logic [OUT_BITS-1:0] acc_next_c,
  output logic                ovf_c,
  output logic                bad_digit_c
);

  // Four extra bits hold acc*10+15 without wrapping.
  localparam int unsigned EXT_W = OUT_BITS + 4;
  localparam logic [EXT_W-1:0] SAT_EXT = EXT_W'({OUT_BITS{1'b1}});

  logic [EXT_W-1:0] acc_ext;
  logic [EXT_W-1:0] sum;

  // Shift-and-add multiply by ten, then clamp to the output range
  always_comb begin
    acc_ext     = EXT_W'(acc);
    sum         = (acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit);
    ovf_c       = (sum > SAT_EXT);
    bad_digit_c = (digit > BCD_MAX);
    acc_next_c  = ovf_c ? {OUT_BITS{1'b1}} : sum[OUT_BITS-1:0];
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, one decade per enabled clock, MS digit first.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned IN_DECADES = 4,
  parameter int unsigned OUT_BITS   = 14
) (
  input  logic                                CLK,
  input  logic                                CLR,
  input  logic                                CE,
  input  logic                                START,
  input  logic [bcd_in_width(IN_DECADES)-1:0] IN,
  output logic [OUT_BITS-1:0]                 Q,
  output logic                                BUSY,
  output logic                                DONE,
  output logic                                ERR,
  output logic                                OVF
);

  localparam int unsigned IN_W  = bcd_in_width(IN_DECADES);
  localparam int unsigned CNT_W = $clog2(IN_DECADES + 1);

  logic [0:0]          state_q,   state_d;
  logic [IN_W-1:0]     sr_q,      sr_d;
  logic [OUT_BITS-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                err_q,     err_d;
  logic                ovf_q,     ovf_d;
  logic [OUT_BITS-1:0] q_q,       q_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                err_out_q, err_out_d;
  logic                ovf_out_q, ovf_out_d;

  logic [3:0]          digit;
  logic [OUT_BITS-1:0] mac_acc;
  logic                mac_ovf;
  logic                mac_bad;
  logic                err_nx;
  logic                ovf_nx;

  assign digit = sr_q[IN_W-1 -: 4];

  bcd_digit_mac #(
    .OUT_BITS (OUT_BITS)
  ) u_mac (
    .acc         (acc_q),
    .digit       (digit),
    .acc_next_c  (mac_acc),
    .ovf_c       (mac_ovf),
    .bad_digit_c (mac_bad)
  );

  // Next-state and output logic; DONE defaults low so it is one CLK wide regardless of CE
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    q_d       = q_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_out_d = err_out_q;
    ovf_out_d = ovf_out_q;
    err_nx    = err_q | mac_bad;
    ovf_nx    = ovf_q | mac_ovf;

    case (state_q)
      ST_IDLE: begin
        if (CE && START) begin
          state_d   = ST_CONV;
          sr_d      = IN;
          acc_d     = '0;
          cnt_d     = CNT_W'(IN_DECADES);
          busy_d    = 1'b1;
          err_d     = 1'b0;
          ovf_d     = 1'b0;
          err_out_d = 1'b0;
          ovf_out_d = 1'b0;
        end
      end
      ST_CONV: begin
        if (CE) begin
          sr_d  = sr_q << 4;
          cnt_d = cnt_q - CNT_W'(1);
          acc_d = mac_acc;
          err_d = err_nx;
          ovf_d = ovf_nx;
          if (cnt_q == CNT_W'(1)) begin
            // An invalid digit wins over overflow and forces a zero result.
            q_d       = err_nx ? '0 : mac_acc;
            err_out_d = err_nx;
            ovf_out_d = ovf_nx & ~err_nx;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous clear taking priority over CE
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      q_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      q_q       <= q_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_out_q <= err_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign Q    = q_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_out_q;
  assign OVF  = ovf_out_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized self-checking bench for bcd_to_bin at 14-bit and 13-bit result widths.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        clr;
  logic        ce;
  logic        start;
  logic [15:0] in_bcd;

  logic [13:0] q14;
  logic        busy14, done14, err14, ovf14;
  logic [12:0] q13;
  logic        busy13, done13, err13, ovf13;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.IN_DECADES(4), .OUT_BITS(14)) dut (
    .CLK(clk), .CLR(clr), .CE(ce), .START(start), .IN(in_bcd),
    .Q(q14), .BUSY(busy14), .DONE(done14), .ERR(err14), .OVF(ovf14)
  );

  bcd_to_bin #(.IN_DECADES(4), .OUT_BITS(13)) dut13 (
    .CLK(clk), .CLR(clr), .CE(ce), .START(start), .IN(in_bcd),
    .Q(q13), .BUSY(busy13), .DONE(done13), .ERR(err13), .OVF(ovf13)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal value of the digits, zero on any bad digit, clamp on overflow
  task automatic model(input logic [15:0] v, input int ob,
                       output int q, output bit e, output bit o);
    int val;
    int maxv;
    logic [3:0] d;
    val  = 0;
    e    = 1'b0;
    o    = 1'b0;
    maxv = (1 << ob) - 1;
    for (int i = 3; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d > 4'd9) e = 1'b1;
      val = val * 10 + int'(d);
    end
    if (e)              q = 0;
    else if (val > maxv) begin q = maxv; o = 1'b1; end
    else                q = val;
  endtask

  task automatic check_result(input logic [15:0] v);
    int  q;
    bit  e;
    bit  o;
    model(v, 14, q, e, o);
    check("q14",   32'(q14),   32'(q));
    check("err14", 32'(err14), 32'(e));
    check("ovf14", 32'(ovf14), 32'(o));
    model(v, 13, q, e, o);
    check("done13", 32'(done13), 32'd1);
    check("q13",    32'(q13),    32'(q));
    check("err13",  32'(err13),  32'(e));
    check("ovf13",  32'(ovf13),  32'(o));
  endtask

  // One conversion with CE high one cycle in ce_div; optionally pokes START while busy
  task automatic run_conv(input logic [15:0] v, input int ce_div, input bit poke);
    int ce_edges;
    bit got;
    int q;
    bit e;
    bit o;
    in_bcd = v;
    start  = 1'b1;
    ce     = 1'b1;
    tick;
    check("busy_accept", 32'(busy14), 32'd1);
    check("err_clr",     32'(err14),  32'd0);
    check("ovf_clr",     32'(ovf14),  32'd0);
    start = poke;
    if (poke) in_bcd = 16'h7777;
    ce_edges = 0;
    got      = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      ce = ((c % ce_div) == (ce_div - 1));
      if (ce) ce_edges++;
      tick;
      if (done14) got = 1'b1;
      else        check("busy_hold", 32'(busy14), 32'd1);
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("ce_edges",  32'(ce_edges), 32'd4);
      check("busy_done", 32'(busy14),   32'd0);
      check_result(v);
    end
    start = 1'b0;
    ce    = 1'b0;
    tick;
    check("done_width", 32'(done14), 32'd0);
    model(v, 14, q, e, o);
    check("q_hold", 32'(q14), 32'(q));
  endtask

  logic [15:0] rv;
  logic [3:0]  nib;
  int          last_done;
  int          pulses;

  initial begin
    clr    = 1'b1;
    ce     = 1'b0;
    start  = 1'b0;
    in_bcd = '0;
    tick;
    tick;
    // reset values; CLR acts even with CE low
    check("rst_q",    32'(q14),    32'd0);
    check("rst_busy", 32'(busy14), 32'd0);
    check("rst_done", 32'(done14), 32'd0);
    check("rst_err",  32'(err14),  32'd0);
    check("rst_ovf",  32'(ovf14),  32'd0);
    clr = 1'b0;
    tick;

    // directed cases
    run_conv(16'h1234, 1, 1'b0);
    run_conv(16'h9999, 1, 1'b0);
    run_conv(16'h12A4, 1, 1'b0);
    run_conv(16'h0042, 1, 1'b0);
    run_conv(16'h0500, 3, 1'b1);
    run_conv(16'h0000, 2, 1'b0);

    // CLR after two digits aborts with no DONE
    in_bcd = 16'h4321;
    start  = 1'b1;
    ce     = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    check("abort_q",    32'(q14),    32'd0);
    check("abort_busy", 32'(busy14), 32'd0);
    check("abort_done", 32'(done14), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (done14) pulses++;
    end
    check("abort_nodone", 32'(pulses), 32'd0);
    run_conv(16'h4321, 1, 1'b0);

    // START held high: back-to-back conversions every five clocks
    in_bcd    = 16'h0001;
    start     = 1'b1;
    ce        = 1'b1;
    last_done = -1;
    pulses    = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (done14) begin
        if (last_done >= 0) check("b2b_period", 32'(c - last_done), 32'd5);
        check("b2b_q", 32'(q14), 32'd1);
        last_done = c;
        pulses++;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd8);
    start = 1'b0;
    for (int c = 0; c < 10 && busy14; c++) tick;
    check("b2b_idle", 32'(busy14), 32'd0);
    tick;

    // random digit words, occasionally with a bad nibble, random CE duty
    for (int n = 0; n < 40; n++) begin
      rv = '0;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 7) == 0) nib = 4'($urandom_range(10, 15));
        else                           nib = 4'($urandom_range(0, 9));
        rv[4*k +: 4] = nib;
      end
      run_conv(rv, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
